ibex_rf_wport_arb: RTL and testbench
====================================

# ibex_rf_wport_arb

Arbiter for the single register-file write port. It shares the port between the writeback-stage result (core path: ID/EX results and LSU load data, already merged) and a background requester, such as the CHERI capability-revocation/tag-clear engine. Core writes always win. Background writes are held in a 2-entry shift queue and retire in idle cycles. An optional starvation guard stalls writeback so that background work is guaranteed forward progress. The block sits between the writeback stage outputs and the register file write inputs.

## Interface
- CheriCapWidth, 91, capability write-data width.
- StarveLimit, 8, cycles a queued background head may wait before a writeback stall is forced (≥2).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous and active-low.
- core_we_i / core_waddr_i / core_wdata_cap_i / core_wdata_int_i / core_wcap_i  in  1/5/CheriCapWidth/32/1  merged writeback write request; no backpressure.
- bg_req_i  in  1  background write valid.
- bg_ready_o  out  1  queue can accept this cycle.
- bg_waddr_i / bg_wdata_cap_i / bg_wdata_int_i / bg_wcap_i  in  5/CheriCapWidth/32/1  background write payload.
- bg_done_o  out  1  pulse when a background entry retires (written or x0-discarded).
- bg_squash_o  out  1  pulse when one or more queued entries are cancelled by a core write.
- stall_wb_o  out  1  registered; upstream guarantees core_we_i=0 in every cycle this is 1.
- rf_we_o / rf_waddr_o / rf_wdata_cap_o / rf_wdata_int_o / rf_wcap_o  out  1/5/CheriCapWidth/32/1  register-file write port.
- rf_wsrc_o  out  1  0 = core, 1 = background (trace only).

## Operation
- Queue: 2 entries (q[0] = head), each holding valid, waddr, cap, int, wcap. bg_ready_o = ~q[1].valid, evaluated on the current state.
- Enqueue: bg_req_i & bg_ready_o writes the payload into the lowest free slot after this cycle's dequeue and squash compaction.
- Port select: if core_we_i, drive the core payload with rf_wsrc_o=0. Else if q[0].valid, drive the head with rf_wsrc_o=1, then dequeue and pulse bg_done_o. Else rf_we_o=0.
- x0 head: when q[0].waddr==0, the entry dequeues with bg_done_o=1 but rf_we_o=0. It still needs a cycle without a core write.
- Data gating: rf_wdata_* are AND-gated by rf_we_o and are zero when no write occurs. rf_wcap_o = selected wcap & rf_we_o.
- Squash: core_we_i with core_waddr_i≠0 invalidates every valid queued entry with a matching waddr. If any entry is invalidated, bg_squash_o=1. Survivors shift toward q[0].
- An entry accepted in the same cycle is ordered after the core write and is not squashed.
- Starvation counter: increments while q[0].valid and the head is not retired, saturating at StarveLimit. It clears on head retire or squash, or when the queue is empty.
- stall_wb_o: set next cycle when the counter is StarveLimit-1 and still incrementing. Cleared the cycle after the head retires.

## Timing
- Minimum latency from background accept to rf_we_o: 1 cycle. The queue is registered; there is no same-cycle bypass.
- Core path is combinational, zero latency.
- Forced retire: at most StarveLimit+1 cycles from head arrival.
- Reset values: queue empty, counter 0, stall_wb_o=0, bg_ready_o=1, bg_done_o=0, bg_squash_o=0, rf_we_o=0, rf data 0, rf_wsrc_o=0.
- Reset asserted mid-operation discards queued entries silently.
- Full queue plus simultaneous retire: bg_ready_o stays 0 that cycle because it is computed from state. Accept resumes next cycle.
- Simultaneous accept, retire and squash are all legal in one cycle.

## Configuration
- IBEX_RF_ARB_STARVE_EN defined: starvation counter and stall_wb_o logic are present.
- IBEX_RF_ARB_STARVE_EN undefined: no counter; stall_wb_o is tied 0; background entries retire only in core-idle cycles, and StarveLimit is unused.

## Structure
- Shared package ibex_pkg gains: rf_wsrc_e {RF_WSRC_CORE, RF_WSRC_BG}, and a packed rf_wr_req_t {waddr, wdata_cap, wdata_int, wcap} parameterised via CheriCapWidth.
- One sub-module, ibex_rf_wport_arb_queue: 2-entry shift queue with per-entry address-match squash, enqueue and dequeue.
- Arbitration, x0 handling and starvation logic stay in the top module.
- Assertions: core_we_i & stall_wb_o never both high; rf_we_o never high for both sources.

## Test plan
- Idle core; bg write {x5, int 0xDEADBEEF, wcap 0} accepted at cycle 0 -> cycle 1: rf_we_o=1, waddr 5, data 0xDEADBEEF, rf_wsrc_o=1, bg_done_o=1.
- Two bg writes (x3, x4) back-to-back with core_we_i=1 continuously -> bg_ready_o=0 after the second accept. With the macro defined, stall_wb_o rises at cycle StarveLimit. x3 retires in the following stall cycle, then x4 follows the same bound.
- Queued x7 and x9; core writes x7 -> bg_squash_o=1; x9 moves to head and retires at the next idle cycle. No write to x7 from background occurs.
- Bg accept of x6 in the same cycle as a core write to x6 -> no squash; background x6 is written afterwards.
- Bg write to x0 -> bg_done_o=1, rf_we_o=0.
- Reset asserted with 2 entries queued -> next cycle queue empty, bg_ready_o=1, all outputs at reset values.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the register-file write-port arbiter.
// Holds the write-source enum and the packed write-request payload.
package ibex_pkg;

  localparam int unsigned CheriCapWidth = 91;

  typedef enum logic {
    RF_WSRC_CORE = 1'b0,
    RF_WSRC_BG   = 1'b1
  } rf_wsrc_e;

  typedef struct packed {
    logic [4:0]               waddr;
    logic [CheriCapWidth-1:0] wdata_cap;
    logic [31:0]              wdata_int;
    logic                     wcap;
  } rf_wr_req_t;

  typedef struct packed {
    logic       valid;
    rf_wr_req_t req;
  } rf_q_entry_t;

endpackage

// File: rtl/ibex_rf_wport_arb_queue.sv
// Two-entry shift queue for background register-file writes.
// Per-cycle order: dequeue head, drop address-matched entries, compact toward q[0], then enqueue.
module ibex_rf_wport_arb_queue
  import ibex_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enq_i,
  input  rf_wr_req_t enq_req_i,
  input  logic       deq_i,
  input  logic       squash_en_i,
  input  logic [4:0] squash_addr_i,
  output logic       head_valid_o,
  output rf_wr_req_t head_req_o,
  output logic       full_o,
  output logic       squash_o,
  output logic       head_squash_o
);

  rf_q_entry_t q_q [2];
  rf_q_entry_t q_d [2];
  logic [1:0]  hit;
  logic        keep0;
  logic        keep1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = squash_en_i & q_q[i].valid & (q_q[i].req.waddr == squash_addr_i);
    end
    keep0 = q_q[0].valid & ~deq_i & ~hit[0];
    keep1 = q_q[1].valid & ~hit[1];

    q_d[0] = '0;
    q_d[1] = '0;
    if (keep0) begin
      q_d[0] = q_q[0];
      if (keep1) q_d[1] = q_q[1];
    end else if (keep1) begin
      q_d[0] = q_q[1];
    end

    // Enqueue is only offered when q[1] was empty, so a free slot always exists here.
    if (enq_i) begin
      if (!q_d[0].valid) q_d[0] = {1'b1, enq_req_i};
      else               q_d[1] = {1'b1, enq_req_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q[0] <= '0;
      q_q[1] <= '0;
    end else begin
      q_q[0] <= q_d[0];
      q_q[1] <= q_d[1];
    end
  end

  assign head_valid_o  = q_q[0].valid;
  assign head_req_o    = q_q[0].req;
  assign full_o        = q_q[1].valid;
  assign squash_o      = |hit;
  assign head_squash_o = hit[0];

endmodule

// File: rtl/ibex_rf_wport_arb.sv
// Register-file write-port arbiter: core writeback always wins, background writes retire when idle.
// Define IBEX_RF_ARB_STARVE_EN to add the starvation counter that forces a writeback stall.
module ibex_rf_wport_arb
  import ibex_pkg::*;
#(
  parameter int unsigned CheriCapWidth = ibex_pkg::CheriCapWidth,
  parameter int unsigned StarveLimit   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     core_we_i,
  input  logic [4:0]               core_waddr_i,
  input  logic [CheriCapWidth-1:0] core_wdata_cap_i,
  input  logic [31:0]              core_wdata_int_i,
  input  logic                     core_wcap_i,
  input  logic                     bg_req_i,
  output logic                     bg_ready_o,
  input  logic [4:0]               bg_waddr_i,
  input  logic [CheriCapWidth-1:0] bg_wdata_cap_i,
  input  logic [31:0]              bg_wdata_int_i,
  input  logic                     bg_wcap_i,
  output logic                     bg_done_o,
  output logic                     bg_squash_o,
  output logic                     stall_wb_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [CheriCapWidth-1:0] rf_wdata_cap_o,
  output logic [31:0]              rf_wdata_int_o,
  output logic                     rf_wcap_o,
  output logic                     rf_wsrc_o
);

  // Handshake: a background write transfers in any cycle where bg_req_i & bg_ready_o;
  // bg_ready_o depends only on registered queue state, never on this cycle's retire.
  rf_wr_req_t bg_req;
  rf_wr_req_t head_req;
  rf_wr_req_t sel_req;
  logic       head_valid;
  logic       q_full;
  logic       any_squash;
  logic       head_squash;
  logic       enq;
  logic       retire;
  logic       bg_wr;
  rf_wsrc_e   wsrc;

  assign bg_req     = '{waddr: bg_waddr_i, wdata_cap: bg_wdata_cap_i,
                        wdata_int: bg_wdata_int_i, wcap: bg_wcap_i};
  assign bg_ready_o = ~q_full;
  assign enq        = bg_req_i & bg_ready_o;
  assign retire     = head_valid & ~core_we_i;
  // An x0 head still consumes an idle slot but never reaches the register file.
  assign bg_wr      = retire & (head_req.waddr != 5'd0);

  ibex_rf_wport_arb_queue u_queue (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enq_i         (enq),
    .enq_req_i     (bg_req),
    .deq_i         (retire),
    .squash_en_i   (core_we_i & (core_waddr_i != 5'd0)),
    .squash_addr_i (core_waddr_i),
    .head_valid_o  (head_valid),
    .head_req_o    (head_req),
    .full_o        (q_full),
    .squash_o      (any_squash),
    .head_squash_o (head_squash)
  );

  always_comb begin
    sel_req = '0;
    wsrc    = RF_WSRC_CORE;
    if (core_we_i) begin
      sel_req = '{waddr: core_waddr_i, wdata_cap: core_wdata_cap_i,
                  wdata_int: core_wdata_int_i, wcap: core_wcap_i};
    end else if (bg_wr) begin
      sel_req = head_req;
      wsrc    = RF_WSRC_BG;
    end
  end

  assign rf_we_o        = core_we_i | bg_wr;
  assign rf_waddr_o     = sel_req.waddr & {5{rf_we_o}};
  assign rf_wdata_cap_o = sel_req.wdata_cap & {CheriCapWidth{rf_we_o}};
  assign rf_wdata_int_o = sel_req.wdata_int & {32{rf_we_o}};
  assign rf_wcap_o      = sel_req.wcap & rf_we_o;
  assign rf_wsrc_o      = logic'(wsrc);
  assign bg_done_o      = retire;
  assign bg_squash_o    = any_squash;

`ifdef IBEX_RF_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  logic [CntW-1:0] starve_cnt_q;
  logic [CntW-1:0] starve_cnt_d;
  logic            stall_q;
  logic            stall_d;
  logic            cnt_inc;

  always_comb begin
    cnt_inc      = head_valid & ~retire & ~head_squash;
    starve_cnt_d = starve_cnt_q;
    stall_d      = stall_q;
    if (!cnt_inc)                                  starve_cnt_d = '0;
    else if (starve_cnt_q != CntW'(StarveLimit))   starve_cnt_d = starve_cnt_q + 1'b1;
    // Stall is raised one cycle ahead so the head is guaranteed an idle slot.
    if (retire)                                                    stall_d = 1'b0;
    else if (cnt_inc && (starve_cnt_q == CntW'(StarveLimit - 1)))  stall_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_wb_o = stall_q;
`else
  assign stall_wb_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (StarveLimit >= 2) else $error("StarveLimit must be at least 2");
      assert (!(core_we_i && stall_wb_o)) else $error("core write during writeback stall");
      assert (!(core_we_i && bg_wr)) else $error("write port driven by both sources");
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_arb.sv
// Directed bench for ibex_rf_wport_arb; stall checks follow IBEX_RF_ARB_STARVE_EN.
module tb_ibex_rf_wport_arb;

  localparam int unsigned CW    = 91;
  localparam int unsigned LIMIT = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          core_we_i;
  logic [4:0]    core_waddr_i;
  logic [CW-1:0] core_wdata_cap_i;
  logic [31:0]   core_wdata_int_i;
  logic          core_wcap_i;
  logic          bg_req_i;
  logic          bg_ready_o;
  logic [4:0]    bg_waddr_i;
  logic [CW-1:0] bg_wdata_cap_i;
  logic [31:0]   bg_wdata_int_i;
  logic          bg_wcap_i;
  logic          bg_done_o;
  logic          bg_squash_o;
  logic          stall_wb_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [CW-1:0] rf_wdata_cap_o;
  logic [31:0]   rf_wdata_int_o;
  logic          rf_wcap_o;
  logic          rf_wsrc_o;

  int n_assert = 0;
  int n_fail   = 0;

  ibex_rf_wport_arb #(.CheriCapWidth(CW), .StarveLimit(LIMIT)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .core_we_i        (core_we_i),
    .core_waddr_i     (core_waddr_i),
    .core_wdata_cap_i (core_wdata_cap_i),
    .core_wdata_int_i (core_wdata_int_i),
    .core_wcap_i      (core_wcap_i),
    .bg_req_i         (bg_req_i),
    .bg_ready_o       (bg_ready_o),
    .bg_waddr_i       (bg_waddr_i),
    .bg_wdata_cap_i   (bg_wdata_cap_i),
    .bg_wdata_int_i   (bg_wdata_int_i),
    .bg_wcap_i        (bg_wcap_i),
    .bg_done_o        (bg_done_o),
    .bg_squash_o      (bg_squash_o),
    .stall_wb_o       (stall_wb_o),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_cap_o   (rf_wdata_cap_o),
    .rf_wdata_int_o   (rf_wdata_int_o),
    .rf_wcap_o        (rf_wcap_o),
    .rf_wsrc_o        (rf_wsrc_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  function automatic logic [CW-1:0] cap_of(input logic [31:0] v);
    return {v, 59'h0};
  endfunction

  // Driver tasks
  task automatic drive_core(input logic we, input logic [4:0] a, input logic [31:0] v,
                            input logic wc);
    core_we_i        = we;
    core_waddr_i     = a;
    core_wdata_int_i = v;
    core_wdata_cap_i = cap_of(v);
    core_wcap_i      = wc;
  endtask

  task automatic drive_bg(input logic req, input logic [4:0] a, input logic [31:0] v,
                          input logic wc);
    bg_req_i       = req;
    bg_waddr_i     = a;
    bg_wdata_int_i = v;
    bg_wdata_cap_i = cap_of(~v);
    bg_wcap_i      = wc;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [4:0] a, input logic [31:0] v,
                           input logic [CW-1:0] cap, input logic wc, input logic src);
    chk({tag, ".we"},   128'(rf_we_o), 128'(1'b1));
    chk({tag, ".addr"}, 128'(rf_waddr_o), 128'(a));
    chk({tag, ".int"},  128'(rf_wdata_int_o), 128'(v));
    chk({tag, ".cap"},  128'(rf_wdata_cap_o), 128'(cap));
    chk({tag, ".wcap"}, 128'(rf_wcap_o), 128'(wc));
    chk({tag, ".src"},  128'(rf_wsrc_o), 128'(src));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".we"},   128'(rf_we_o), 128'(1'b0));
    chk({tag, ".addr"}, 128'(rf_waddr_o), 128'(5'd0));
    chk({tag, ".int"},  128'(rf_wdata_int_o), 128'(32'd0));
    chk({tag, ".cap"},  128'(rf_wdata_cap_o), 128'(0));
    chk({tag, ".wcap"}, 128'(rf_wcap_o), 128'(1'b0));
  endtask

  initial begin
    rst_ni = 1'b0;
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();

    // Reset state
    chk("rst.ready",  128'(bg_ready_o), 128'(1'b1));
    chk("rst.done",   128'(bg_done_o), 128'(1'b0));
    chk("rst.squash", 128'(bg_squash_o), 128'(1'b0));
    chk("rst.stall",  128'(stall_wb_o), 128'(1'b0));
    chk("rst.src",    128'(rf_wsrc_o), 128'(1'b0));
    chk_idle("rst");
    rst_ni = 1'b1;
    next_cycle();

    // Single background write, one-cycle latency
    drive_bg(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    settle();
    chk("t1.ready", 128'(bg_ready_o), 128'(1'b1));
    chk_idle("t1.accept");
    next_cycle();
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk_write("t1.wr", 5'd5, 32'hDEADBEEF, cap_of(~32'hDEADBEEF), 1'b0, 1'b1);
    chk("t1.done", 128'(bg_done_o), 128'(1'b1));
    next_cycle();
    chk_idle("t1.after");
    chk("t1.done0", 128'(bg_done_o), 128'(1'b0));

    // Back-to-back x3, x4 under continuous core writes
    drive_core(1'b1, 5'd1, 32'h11, 1'b0);
    drive_bg(1'b1, 5'd3, 32'h33, 1'b1);
    settle();
    chk("t2.rdy_a", 128'(bg_ready_o), 128'(1'b1));
    chk_write("t2.core", 5'd1, 32'h11, cap_of(32'h11), 1'b0, 1'b0);
    next_cycle();
    drive_bg(1'b1, 5'd4, 32'h44, 1'b0);
    settle();
    chk("t2.rdy_b", 128'(bg_ready_o), 128'(1'b1));
    next_cycle();
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk("t2.full", 128'(bg_ready_o), 128'(1'b0));
`ifdef IBEX_RF_ARB_STARVE_EN
    // x3 reached the head one cycle ago (k=0); this is k=1.
    for (int k = 1; k < LIMIT; k++) begin
      chk("t2.nostall3", 128'(stall_wb_o), 128'(1'b0));
      next_cycle();
    end
    chk("t2.stall3", 128'(stall_wb_o), 128'(1'b1));
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk_write("t2.x3", 5'd3, 32'h33, cap_of(~32'h33), 1'b1, 1'b1);
    chk("t2.rdy_ret", 128'(bg_ready_o), 128'(1'b0));
    next_cycle();
    drive_core(1'b1, 5'd1, 32'h11, 1'b0);
    for (int j = 0; j < LIMIT; j++) begin
      chk("t2.nostall4", 128'(stall_wb_o), 128'(1'b0));
      next_cycle();
    end
    chk("t2.stall4", 128'(stall_wb_o), 128'(1'b1));
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk_write("t2.x4", 5'd4, 32'h44, cap_of(~32'h44), 1'b0, 1'b1);
    next_cycle();
    chk("t2.stall_clr", 128'(stall_wb_o), 128'(1'b0));
    chk_idle("t2.after");
`else
    for (int k = 0; k < 12; k++) begin
      chk("t2.hold_rdy", 128'(bg_ready_o), 128'(1'b0));
      chk("t2.nostall", 128'(stall_wb_o), 128'(1'b0));
      chk("t2.hold_src", 128'(rf_wsrc_o), 128'(1'b0));
      next_cycle();
    end
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk_write("t2.x3", 5'd3, 32'h33, cap_of(~32'h33), 1'b1, 1'b1);
    chk("t2.rdy_ret", 128'(bg_ready_o), 128'(1'b0));
    next_cycle();
    chk_write("t2.x4", 5'd4, 32'h44, cap_of(~32'h44), 1'b0, 1'b1);
    chk("t2.rdy_back", 128'(bg_ready_o), 128'(1'b1));
    next_cycle();
    chk_idle("t2.after");
`endif

    // Queue x7, x9; core write to x7 squashes it
    drive_core(1'b1, 5'd2, 32'h22, 1'b0);
    drive_bg(1'b1, 5'd7, 32'h77, 1'b0);
    next_cycle();
    drive_bg(1'b1, 5'd9, 32'h99, 1'b0);
    next_cycle();
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    drive_core(1'b1, 5'd7, 32'hC7, 1'b1);
    settle();
    chk("t3.squash", 128'(bg_squash_o), 128'(1'b1));
    chk_write("t3.core", 5'd7, 32'hC7, cap_of(32'hC7), 1'b1, 1'b0);
    next_cycle();
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk("t3.sq0", 128'(bg_squash_o), 128'(1'b0));
    chk_write("t3.x9", 5'd9, 32'h99, cap_of(~32'h99), 1'b0, 1'b1);
    chk("t3.done", 128'(bg_done_o), 128'(1'b1));
    next_cycle();
    chk_idle("t3.after");
    chk("t3.done0", 128'(bg_done_o), 128'(1'b0));

    // Same-cycle accept and core write to x6: no squash
    drive_core(1'b1, 5'd6, 32'hC6, 1'b0);
    drive_bg(1'b1, 5'd6, 32'h66, 1'b1);
    settle();
    chk("t4.nosquash", 128'(bg_squash_o), 128'(1'b0));
    chk_write("t4.core", 5'd6, 32'hC6, cap_of(32'hC6), 1'b0, 1'b0);
    next_cycle();
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk_write("t4.bg", 5'd6, 32'h66, cap_of(~32'h66), 1'b1, 1'b1);
    chk("t4.done", 128'(bg_done_o), 128'(1'b1));
    next_cycle();

    // x0 background write retires without writing
    drive_bg(1'b1, 5'd0, 32'h1234, 1'b1);
    next_cycle();
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk("t5.done", 128'(bg_done_o), 128'(1'b1));
    chk_idle("t5.x0");
    next_cycle();
    chk("t5.done0", 128'(bg_done_o), 128'(1'b0));

    // Reset with two entries queued
    drive_core(1'b1, 5'd1, 32'h11, 1'b0);
    drive_bg(1'b1, 5'd10, 32'hAA, 1'b0);
    next_cycle();
    drive_bg(1'b1, 5'd11, 32'hBB, 1'b0);
    next_cycle();
    drive_bg(1'b0, 5'd0, 32'd0, 1'b0);
    settle();
    chk("t6.full", 128'(bg_ready_o), 128'(1'b0));
    rst_ni = 1'b0;
    drive_core(1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    chk("t6.ready", 128'(bg_ready_o), 128'(1'b1));
    chk("t6.done",  128'(bg_done_o), 128'(1'b0));
    chk("t6.stall", 128'(stall_wb_o), 128'(1'b0));
    chk("t6.src",   128'(rf_wsrc_o), 128'(1'b0));
    chk_idle("t6.rst");
    rst_ni = 1'b1;
    next_cycle();
    chk("t6.done_post", 128'(bg_done_o), 128'(1'b0));
    chk_idle("t6.post");
    next_cycle();
    chk("t6.done_post2", 128'(bg_done_o), 128'(1'b0));
    chk_idle("t6.post2");

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
